pool_reader_2x2: RTL and testbench
==================================

Name: pool_reader_2x2

Overview:
- Reader/back-end of the convolution result buffer: once the MAC pass has filled the 16-bit Q5.10 feature map, this block reads it back in 2x2 windows.
- Computes the signed maximum of each window, with optional ReLU, and writes the pooled value back into the same single-port buffer through the pool_out/choose path.
- Sits beside the MAC unit in the accelerator and shares its buffer port (we, addr, dout) under sequencer control.

Parameters:
- DATA_W, 16, sample width (1s 5i 10d, two's complement)
- ADDR_W, 11, buffer address width (buffer depth 1089)
- DIM_W, 6, width of the feature-map dimension field (max 33)

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begins a pooling pass; ignored while busy
- cfg_dim  in  DIM_W  input map side length D (row-major, square)
- cfg_in_base  in  ADDR_W  buffer address of input element (0,0)
- cfg_out_base  in  ADDR_W  buffer address of pooled element (0,0)
- relu_en  in  1  1: clamp negative maxima to 0
- ram_dout  in  DATA_W  buffer read data, valid one cycle after the address is presented with we=0
- ram_we  out  1  buffer write enable
- ram_addr  out  ADDR_W  buffer address
- pool_out  out  DATA_W  write data toward the buffer
- choose  out  1  buffer input select: 0 while busy (pool_out), 1 otherwise (MAC)
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset values: ram_we=0, ram_addr=0, pool_out=0, choose=1, busy=0, done=0. FSM goes to IDLE and all counters clear. Reset mid-pass aborts immediately; no further writes occur.
- Configuration (cfg_*, relu_en) is latched on an accepted start. Changes during a pass have no effect.
- Pooled size P = floor(D/2). For odd D the last row and column are dropped. If P=0, the block goes IDLE -> DONE -> IDLE with no buffer access.
- FSM states: IDLE, RD0, RD1, RD2, RD3, CAP, WR, DONE.
- Per window (r,c) with base a = in_base + 2r*D + 2c:
  - RD0 presents a, RD1 presents a+1, RD2 presents a+D, RD3 presents a+D+1. ram_we=0 in all four.
  - Data is captured one cycle after each address: the RD1/RD2/RD3/CAP cycles capture elements 0..3.
  - A running signed max is updated on each capture.
- WR cycle: ram_we=1, ram_addr = out_base + r*P + c, pool_out = relu_en ? max(m,0) : m.
- Each window takes exactly 6 cycles. Raster order: c increments; at c=P-1, c wraps to 0 and r increments.
- After the WR of window (P-1,P-1) the FSM enters DONE: done=1 and busy=0 for that cycle, then IDLE.
- Timing: start accepted in cycle 0 gives RD0 in cycle 1, the first WR in cycle 6, and done in cycle 6*P*P+1.
- busy=1 and choose=0 from RD0 through WR inclusive.
- ram_addr, ram_we and pool_out are registered outputs. ram_addr holds its last value in IDLE/DONE.
- Address arithmetic is modulo 2^ADDR_W; keeping regions inside depth 1089 is the software's job. In-place use (out_base=in_base) is legal because every write address is at or below any still-unread input address.
- Comparison is signed 16-bit; equal values need no tie-break. The initial max is the first captured element, not 0.
- start coincident with DONE is ignored.

Decomposition:
- Shared accelerator package holds:
  - DATA_W/ADDR_W constants
  - FSM state encoding (IDLE..DONE, 3 bits)
  - Q5.10 constants (ZERO=16'h0000, MIN=16'h8000)
- One natural sub-module: max4_signed. It is a registered running-max accumulator with load/update/clear, keeping the compare datapath separate from the address FSM.

Test Plan:
- D=4, in_base=0, out_base=100, map values 0..15 (Q5.10 integers i<<10), relu_en=0 -> writes at 100..103 of 5,7,13,15 (<<10); done at cycle 25.
- D=2, all four values negative {-1.0,-2.0,-0.5,-3.0}, i.e. 16'hFC00, 16'hF800, 16'hFE00, 16'hF400 -> relu_en=0 writes 16'hFE00; relu_en=1 writes 16'h0000.
- D=5 (odd), in_base=0, out_base=200 -> exactly 4 writes at 200..203; row 4 and column 4 addresses are never read; done at cycle 25.
- In-place: D=32, in_base=out_base=0, random data -> 256 pooled results match a golden model; busy=0 only after the final write.
- start pulsed again mid-pass and cfg_dim changed mid-pass -> no restart; results follow the latched config.
- rstn asserted during the RD2 of window 3, then released and start issued -> no write to window 3's address while reset; a fresh pass completes correctly. D=0 and D=1 -> done pulse at cycle 2 with no ram_we.

Source files
------------

// File: rtl/pool_reader_2x2_pkg.sv
// Shared accelerator definitions for the pooling back-end: widths, FSM encoding
// and Q5.10 constants.
package pool_reader_2x2_pkg;

  localparam int POOL_DATA_W = 16;
  localparam int POOL_ADDR_W = 11;
  localparam int POOL_DIM_W  = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_RD1  = 3'd2,
    ST_RD2  = 3'd3,
    ST_RD3  = 3'd4,
    ST_CAP  = 3'd5,
    ST_WR   = 3'd6,
    ST_DONE = 3'd7
  } pool_state_t;

  localparam logic signed [POOL_DATA_W-1:0] Q_ZERO = 16'sh0000;
  localparam logic signed [POOL_DATA_W-1:0] Q_MIN  = 16'sh8000;

endpackage

// File: rtl/pool_reader_2x2_max4.sv
// Registered running signed maximum over the four samples of a pooling window.
// max_val already folds in the sample currently on din.
module max4_signed
  import pool_reader_2x2_pkg::*;
#(
  parameter int DATA_W = POOL_DATA_W
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     load,
  input  logic                     update,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] max_val
);

  logic signed [DATA_W-1:0] max_p0;

  always_comb begin
    max_val = max_p0;
    if (load || (din > max_p0))
      max_val = din;
  end

  // running-max register, first sample loads unconditionally
  always_ff @(posedge clk) begin
    if (clear)
      max_p0 <= DATA_W'(Q_MIN);
    else if (load || update)
      max_p0 <= max_val;
  end

endmodule

// File: rtl/pool_reader_2x2.sv
// 2x2 max-pool reader: walks the feature map window by window through the
// shared single-port buffer and writes each pooled maximum back into it.
module pool_reader_2x2
  import pool_reader_2x2_pkg::*;
#(
  parameter int DATA_W = POOL_DATA_W,
  parameter int ADDR_W = POOL_ADDR_W,
  parameter int DIM_W  = POOL_DIM_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [DIM_W-1:0]         cfg_dim,
  input  logic [ADDR_W-1:0]        cfg_in_base,
  input  logic [ADDR_W-1:0]        cfg_out_base,
  input  logic                     relu_en,
  input  logic signed [DATA_W-1:0] ram_dout,
  output logic                     ram_we,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic signed [DATA_W-1:0] pool_out,
  output logic                     choose,
  output logic                     busy,
  output logic                     done
);

  localparam int P_W = DIM_W - 1;

  pool_state_t state;

  logic [DIM_W-1:0]  dim_q;
  logic              relu_q;
  logic              empty_pend;
  logic              accept;

  logic [P_W-1:0]    pdim;
  logic [P_W-1:0]    row;
  logic [P_W-1:0]    col;
  logic              last_col;
  logic              last_win;

  logic [ADDR_W-1:0] dim_a;
  logic [ADDR_W-1:0] win_addr;
  logic [ADDR_W-1:0] row_addr;
  logic [ADDR_W-1:0] out_addr;
  logic [ADDR_W-1:0] next_row_addr;
  logic [ADDR_W-1:0] next_win_addr;

  logic                     cap_first;
  logic                     cap_next;
  logic signed [DATA_W-1:0] max_val;

  function automatic logic signed [DATA_W-1:0] relu_clamp(
    input logic signed [DATA_W-1:0] v,
    input logic                     en
  );
    return (en && (v < DATA_W'(Q_ZERO))) ? DATA_W'(Q_ZERO) : v;
  endfunction

  assign accept = (state == ST_IDLE) && !empty_pend && start;

  always_ff @(posedge clk) begin
    if (accept) begin
      dim_q  <= cfg_dim;
      relu_q <= relu_en;
    end
  end

  assign pdim     = dim_q[DIM_W-1:1];
  assign dim_a    = ADDR_W'(dim_q);
  assign last_col = (col == pdim - P_W'(1));
  assign last_win = last_col && (row == pdim - P_W'(1));

  // Odd maps simply skip the trailing column: the next window row starts 2*D on.
  assign next_row_addr = row_addr + (dim_a << 1);
  assign next_win_addr = last_col ? next_row_addr : win_addr + ADDR_W'(2);

  // read data trails the address by one cycle, so captures run RD1..CAP
  assign cap_first = (state == ST_RD1);
  assign cap_next  = (state == ST_RD2) || (state == ST_RD3) || (state == ST_CAP);

  max4_signed #(
    .DATA_W (DATA_W)
  ) u_max (
    .clk     (clk),
    .clear   (accept),
    .load    (cap_first),
    .update  (cap_next),
    .din     (ram_dout),
    .max_val (max_val)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      pool_out   <= '0;
      choose     <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      empty_pend <= 1'b0;
      row        <= '0;
      col        <= '0;
      win_addr   <= '0;
      row_addr   <= '0;
      out_addr   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (empty_pend) begin
            empty_pend <= 1'b0;
            done       <= 1'b1;
            state      <= ST_DONE;
          end else if (start) begin
            row      <= '0;
            col      <= '0;
            win_addr <= cfg_in_base;
            row_addr <= cfg_in_base;
            out_addr <= cfg_out_base;
            if (cfg_dim[DIM_W-1:1] == '0) begin
              empty_pend <= 1'b1;
            end else begin
              state    <= ST_RD0;
              ram_addr <= cfg_in_base;
              busy     <= 1'b1;
              choose   <= 1'b0;
            end
          end
        end
        ST_RD0: begin
          ram_addr <= win_addr + ADDR_W'(1);
          state    <= ST_RD1;
        end
        ST_RD1: begin
          ram_addr <= win_addr + dim_a;
          state    <= ST_RD2;
        end
        ST_RD2: begin
          ram_addr <= win_addr + dim_a + ADDR_W'(1);
          state    <= ST_RD3;
        end
        ST_RD3: begin
          state <= ST_CAP;
        end
        ST_CAP: begin
          ram_we   <= 1'b1;
          ram_addr <= out_addr;
          pool_out <= relu_clamp(max_val, relu_q);
          state    <= ST_WR;
        end
        ST_WR: begin
          ram_we   <= 1'b0;
          out_addr <= out_addr + ADDR_W'(1);
          if (last_win) begin
            done   <= 1'b1;
            busy   <= 1'b0;
            choose <= 1'b1;
            state  <= ST_DONE;
          end else begin
            ram_addr <= next_win_addr;
            win_addr <= next_win_addr;
            state    <= ST_RD0;
            if (last_col) begin
              col      <= '0;
              row      <= row + P_W'(1);
              row_addr <= next_row_addr;
            end else begin
              col <= col + P_W'(1);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool_reader_2x2.sv
// Scoreboard bench for pool_reader_2x2: a behavioural buffer plus a window-max
// reference model feeding expected writes and done cycles to a monitor.
module tb_pool_reader_2x2;
  import pool_reader_2x2_pkg::*;

  localparam int DW = 16;
  localparam int AW = 11;
  localparam int MW = 6;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [MW-1:0] cfg_dim = '0;
  logic [AW-1:0] cfg_in_base = '0;
  logic [AW-1:0] cfg_out_base = '0;
  logic          relu_en = 1'b0;
  logic [DW-1:0] ram_dout;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] pool_out;
  logic          choose;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  pool_reader_2x2 dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .cfg_dim      (cfg_dim),
    .cfg_in_base  (cfg_in_base),
    .cfg_out_base (cfg_out_base),
    .relu_en      (relu_en),
    .ram_dout     (ram_dout),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .pool_out     (pool_out),
    .choose       (choose),
    .busy         (busy),
    .done         (done)
  );

  // behavioural single-port buffer with a backdoor load port
  logic [DW-1:0] mem [0:DEPTH-1];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (ram_we) mem[ram_addr] <= pool_out;
    ram_dout <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];
  bit  allowed [0:DEPTH-1];
  int  bad_reads = 0;
  int  n_tests = 0;
  int  n_fail = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin : monitor
    wr_t e;
    int  t;
    if (ram_we) begin
      check("write_expected", 64'(wr_q.size() > 0), 64'd1);
      if (wr_q.size() > 0) begin
        e = wr_q.pop_front();
        check("write", {busy, choose, ram_addr, pool_out}, {1'b1, 1'b0, e.addr, e.data});
      end
    end else if (busy) begin
      if (!allowed[ram_addr] || choose) bad_reads++;
    end
    if (done) begin
      check("done_expected", 64'(done_q.size() > 0), 64'd1);
      if (done_q.size() > 0) begin
        t = done_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(t));
        check("done_state", {busy, choose, 32'(wr_q.size())}, {1'b0, 1'b1, 32'd0});
      end
    end
  end

  task automatic load_word(input int a, input logic [DW-1:0] d);
    ld_en = 1'b1;
    ld_addr = AW'(a);
    ld_data = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic load_rand(input int base, input int n);
    for (int i = 0; i < n; i++) load_word((base + i) % DEPTH, DW'($urandom));
  endtask

  // Reference: each pooled value is the signed max of its 2x2 block, optionally clamped.
  task automatic start_pass(input int d, input int ib, input int ob, input bit relu);
    int p;
    int a;
    logic signed [DW-1:0] m;
    logic signed [DW-1:0] v;
    wr_t e;
    p = d / 2;
    for (int i = 0; i < DEPTH; i++) allowed[i] = 1'b0;
    bad_reads = 0;
    m = '0;
    for (int r = 0; r < p; r++) begin
      for (int c = 0; c < p; c++) begin
        for (int dr = 0; dr < 2; dr++) begin
          for (int dc = 0; dc < 2; dc++) begin
            a = (ib + (2 * r + dr) * d + 2 * c + dc) % DEPTH;
            allowed[a] = 1'b1;
            v = mem[a];
            if ((dr == 0 && dc == 0) || v > m) m = v;
          end
        end
        if (relu && m < 0) m = '0;
        e.addr = AW'((ob + r * p + c) % DEPTH);
        e.data = m;
        wr_q.push_back(e);
      end
    end
    cfg_dim = MW'(d);
    cfg_in_base = AW'(ib);
    cfg_out_base = AW'(ob);
    relu_en = relu;
    start = 1'b1;
    done_q.push_back(cyc + ((p == 0) ? 2 : 6 * p * p + 1));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_pass(input int budget);
    int n;
    n = 0;
    while (done_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("pass_timeout", 64'(done_q.size()), 64'd0);
    done_q.delete();
    @(posedge clk);
    #1;
    check("bad_reads", 64'(bad_reads), 64'd0);
    check("writes_left", 64'(wr_q.size()), 64'd0);
    wr_q.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int s;
    int n;
    int d;
    logic [DW-1:0] sentinel;

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_values", {ram_we, ram_addr, pool_out, choose, busy, done},
          {1'b0, 11'd0, 16'd0, 1'b1, 1'b0, 1'b0});
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // ramp map, D=4
    for (int i = 0; i < 16; i++) load_word(i, DW'(i << 10));
    start_pass(4, 0, 100, 1'b0);
    wait_pass(200);
    check("ramp_fixed_103", {48'd0, mem[103]}, 64'h3C00);

    // all-negative window with and without ReLU
    load_word(300, 16'hFC00);
    load_word(301, 16'hF800);
    load_word(302, 16'hFE00);
    load_word(303, 16'hF400);
    start_pass(2, 300, 310, 1'b0);
    wait_pass(50);
    check("neg_max", {48'd0, mem[310]}, 64'hFE00);
    start_pass(2, 300, 311, 1'b1);
    wait_pass(50);
    check("neg_relu", {48'd0, mem[311]}, 64'h0000);

    // odd dimension drops last row/column
    load_rand(0, 25);
    start_pass(5, 0, 200, 1'b0);
    wait_pass(200);

    // empty maps
    start_pass(0, 0, 700, 1'b0);
    wait_pass(20);
    start_pass(1, 0, 700, 1'b1);
    wait_pass(20);

    // in-place on the full map
    load_rand(0, 1024);
    start_pass(32, 0, 0, 1'($urandom_range(0, 1)));
    wait_pass(7000);

    // restart attempts and config changes mid-pass, then start on the done cycle
    load_rand(400, 36);
    start_pass(6, 400, 500, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    cfg_dim = 6'd10;
    relu_en = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (done_q.size() != 0 && cyc != done_q[0] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("no_restart_busy", {63'd0, busy}, 64'd0);
    wait_pass(10);

    // random passes in disjoint regions
    for (int k = 0; k < 4; k++) begin
      d = $urandom_range(0, 12);
      s = $urandom_range(0, 600);
      load_rand(s, d * d);
      start_pass(d, s, $urandom_range(1000, 1900), 1'($urandom_range(0, 1)));
      wait_pass(1000);
    end

    // reset during RD2 of window 3, then a fresh pass
    load_rand(0, 64);
    load_word(603, 16'h1234);
    sentinel = 16'h1234;
    s = cyc;
    start_pass(8, 0, 600, 1'b0);
    while (cyc < s + 21) begin
      @(posedge clk);
      #1;
    end
    rstn = 1'b0;
    #1;
    check("abort_pending_writes", 64'(wr_q.size()), 64'd13);
    wr_q.delete();
    done_q.delete();
    check("abort_reset_values", {ram_we, ram_addr, pool_out, choose, busy, done},
          {1'b0, 11'd0, 16'd0, 1'b1, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_write", {48'd0, mem[603]}, {48'd0, sentinel});
    rstn = 1'b1;
    @(posedge clk);
    #1;
    start_pass(8, 0, 600, 1'b1);
    wait_pass(500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
